// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Control/target inputs and PC outputs of the fetch PC generator
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;
  logic        stall;
  logic        imem_ready;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        nop;
  logic        misaligned;

  modport master (
    input  stall, imem_ready, jump, jump_target, branch_taken, branch_target,
    output pc, pc_valid, nop, misaligned
  );

  modport slave (
    output stall, imem_ready, jump, jump_target, branch_taken, branch_target,
    input  pc, pc_valid, nop, misaligned
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Fetch PC generator with jump/branch redirect and flush bubble
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  wire             clk,
  input  wire             rst,
  pc_fetch_unit_if.master fetch_io
);

  localparam logic [1:0] c_BOOT  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        nop_q, nop_d;
  logic        misaligned_q, misaligned_d;

  logic        w_redirect;
  logic [31:0] w_target;

  // Jump outranks branch; either one overrides stall and memory back-pressure.
  assign w_redirect = fetch_io.jump | fetch_io.branch_taken;
  assign w_target   = fetch_io.jump ? fetch_io.jump_target : fetch_io.branch_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= c_BOOT;
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
      nop_q        <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      nop_q        <= nop_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_BOOT:  state_d = c_FETCH;
      c_FETCH: if (w_redirect) state_d = c_FLUSH;
      c_FLUSH: state_d = w_redirect ? c_FLUSH : c_FETCH;
      default: state_d = c_BOOT;
    endcase
  end

  // Output flags are the registered decode of the upcoming state.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    case (state_q)
      c_FETCH: begin
        if (w_redirect) begin
          pc_d         = {w_target[31:2], 2'b00};
          misaligned_d = |w_target[1:0];
        end else if (!fetch_io.stall && fetch_io.imem_ready) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      c_FLUSH: begin
        if (w_redirect) begin
          pc_d         = {w_target[31:2], 2'b00};
          misaligned_d = |w_target[1:0];
        end
      end
      default: pc_d = pc_q;
    endcase
    pc_valid_d = (state_d == c_FETCH);
    nop_d      = (state_d == c_FLUSH);
  end

  assign fetch_io.pc         = pc_q;
  assign fetch_io.pc_valid   = pc_valid_q;
  assign fetch_io.nop        = nop_q;
  assign fetch_io.misaligned = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit against a behavioural model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_fetch_unit_if f();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_io (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the fetch unit should be showing right now.
  logic [31:0] m_pc;
  logic        m_valid, m_nop, m_mis, m_boot;

  function automatic logic [34:0] exp_vec();
    return {m_pc, m_valid, m_nop, m_mis};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_valid = 1'b0; m_nop = 1'b0; m_mis = 1'b0; m_boot = 1'b1;
  endtask

  task automatic idle_inputs();
    f.stall = 1'b0; f.imem_ready = 1'b1; f.jump = 1'b0; f.branch_taken = 1'b0;
    f.jump_target = 32'h0; f.branch_target = 32'h0;
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic step();
    logic [31:0] tgt;
    logic [31:0] n_pc;
    logic        n_valid, n_nop, n_mis, n_boot;
    n_pc = m_pc; n_valid = m_valid; n_nop = m_nop; n_mis = 1'b0; n_boot = 1'b0;
    tgt = f.jump ? f.jump_target : f.branch_target;
    if (m_boot) begin
      n_valid = 1'b1; n_nop = 1'b0;
    end else if (f.jump || f.branch_taken) begin
      n_pc = tgt & 32'hFFFF_FFFC; n_valid = 1'b0; n_nop = 1'b1; n_mis = (tgt % 4) != 0;
    end else if (m_nop) begin
      n_valid = 1'b1; n_nop = 1'b0;
    end else if (!f.stall && f.imem_ready) begin
      n_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    m_pc = n_pc; m_valid = n_valid; m_nop = n_nop; m_mis = n_mis; m_boot = n_boot;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({f.pc, f.pc_valid, f.nop, f.misaligned} !== {RESET_PC, 3'b000}) begin
      failures++;
      $display("FAIL reset_state: got %h/%b%b%b exp %h/000", f.pc, f.pc_valid, f.nop, f.misaligned, RESET_PC);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({f.pc, f.pc_valid, f.nop} !== {32'h100, 2'b10}) begin
      failures++;
      $display("FAIL boot_first_fetch: got %h/%b%b exp 00000100/10", f.pc, f.pc_valid, f.nop);
    end
    repeat (3) step();
    checks++;
    if ({f.pc, f.pc_valid} !== {32'h10C, 1'b1}) begin
      failures++;
      $display("FAIL sequential_advance: got %h/%b exp 0000010c/1", f.pc, f.pc_valid);
    end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    held = f.pc;
    f.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({f.pc, f.pc_valid, f.nop} !== {held, 2'b10} || exp_vec() !== {f.pc, f.pc_valid, f.nop, f.misaligned}) begin
        failures++;
        $display("FAIL stall_hold: got %h/%b%b exp %h/10", f.pc, f.pc_valid, f.nop, held);
      end
    end
    f.stall = 1'b0; f.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({f.pc, f.pc_valid, f.nop} !== {held, 2'b10}) begin
        failures++;
        $display("FAIL imem_not_ready_hold: got %h/%b%b exp %h/10", f.pc, f.pc_valid, f.nop, held);
      end
    end
    f.imem_ready = 1'b1;
  endtask

  task automatic test_branch();
    f.branch_taken = 1'b1; f.branch_target = 32'h200;
    step();
    f.branch_taken = 1'b0;
    checks++;
    if ({f.pc, f.pc_valid, f.nop, f.misaligned} !== {32'h200, 3'b010}) begin
      failures++;
      $display("FAIL branch_flush: got %h/%b%b%b exp 00000200/010", f.pc, f.pc_valid, f.nop, f.misaligned);
    end
    step();
    checks++;
    if ({f.pc, f.pc_valid, f.nop} !== {32'h200, 2'b10}) begin
      failures++;
      $display("FAIL branch_valid: got %h/%b%b exp 00000200/10", f.pc, f.pc_valid, f.nop);
    end
    step();
    checks++;
    if ({f.pc, f.pc_valid} !== {32'h204, 1'b1}) begin
      failures++;
      $display("FAIL branch_advance: got %h/%b exp 00000204/1", f.pc, f.pc_valid);
    end
  endtask

  task automatic test_jump_priority();
    f.jump = 1'b1; f.jump_target = 32'h300;
    f.branch_taken = 1'b1; f.branch_target = 32'h400; f.stall = 1'b1;
    step();
    idle_inputs();
    checks++;
    if ({f.pc, f.pc_valid, f.nop} !== {32'h300, 2'b01}) begin
      failures++;
      $display("FAIL jump_priority: got %h/%b%b exp 00000300/01", f.pc, f.pc_valid, f.nop);
    end
    step();
    checks++;
    if ({f.pc, f.pc_valid, f.nop} !== {32'h300, 2'b10}) begin
      failures++;
      $display("FAIL jump_valid: got %h/%b%b exp 00000300/10", f.pc, f.pc_valid, f.nop);
    end
  endtask

  task automatic test_misaligned_refl();
    f.jump = 1'b1; f.jump_target = 32'h302;
    step();
    checks++;
    if ({f.pc, f.pc_valid, f.nop, f.misaligned} !== {32'h300, 3'b011}) begin
      failures++;
      $display("FAIL misaligned_jump: got %h/%b%b%b exp 00000300/011", f.pc, f.pc_valid, f.nop, f.misaligned);
    end
    f.jump_target = 32'h500;
    step();
    f.jump = 1'b0;
    checks++;
    if ({f.pc, f.pc_valid, f.nop, f.misaligned} !== {32'h500, 3'b010}) begin
      failures++;
      $display("FAIL flush_redirect: got %h/%b%b%b exp 00000500/010", f.pc, f.pc_valid, f.nop, f.misaligned);
    end
    step();
    checks++;
    if ({f.pc, f.pc_valid, f.nop, f.misaligned} !== {32'h500, 3'b100}) begin
      failures++;
      $display("FAIL flush_extend_valid: got %h/%b%b%b exp 00000500/100", f.pc, f.pc_valid, f.nop, f.misaligned);
    end
  endtask

  task automatic test_wrap();
    f.jump = 1'b1; f.jump_target = 32'hFFFF_FFFC;
    step();
    f.jump = 1'b0;
    step();
    step();
    checks++;
    if ({f.pc, f.pc_valid} !== {32'h0, 1'b1}) begin
      failures++;
      $display("FAIL pc_wrap: got %h/%b exp 00000000/1", f.pc, f.pc_valid);
    end
  endtask

  task automatic test_reset_mid_flush();
    f.branch_taken = 1'b1; f.branch_target = 32'h600;
    step();
    idle_inputs();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({f.pc, f.pc_valid, f.nop, f.misaligned} !== {RESET_PC, 3'b000}) begin
      failures++;
      $display("FAIL async_reset_flush: got %h/%b%b%b exp %h/000", f.pc, f.pc_valid, f.nop, f.misaligned, RESET_PC);
    end
    #1 rst = 1'b0;
    step();
    checks++;
    if ({f.pc, f.pc_valid, f.nop} !== {RESET_PC, 2'b10}) begin
      failures++;
      $display("FAIL reboot_fetch: got %h/%b%b exp %h/10", f.pc, f.pc_valid, f.nop, RESET_PC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      f.stall         = ($urandom % 4) == 0;
      f.imem_ready    = ($urandom % 4) != 0;
      f.jump          = ($urandom % 10) == 0;
      f.branch_taken  = ($urandom % 7) == 0;
      f.jump_target   = $urandom;
      f.branch_target = $urandom;
      step();
      checks++;
      if ({f.pc, f.pc_valid, f.nop, f.misaligned} !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d: got %h/%b%b%b exp %h/%b%b%b", i, f.pc, f.pc_valid, f.nop,
                 f.misaligned, m_pc, m_valid, m_nop, m_mis);
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_hold();
    test_branch();
    test_jump_priority();
    test_misaligned_refl();
    test_wrap();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
